// File: rtl/sram_bw_wr_arb.sv
// sram_bw_wr_arb
// Write-port arbiter and read scheduler for the byte-write line SRAM
// (1-cycle read latency). A full-line fill port and a byte-masked store
// port share one SRAM write port. Reads that would race an in-flight write
// are held off.
//
// Handshake: every request port follows valid/ready. A transfer happens on
// the rising clk edge where req and rdy are both high. rdy is combinational
// and may depend on req. The requester holds addr/data stable while req is
// high and rdy is low.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   fill_req/adr/dat   full-line write requester, fill_rdy accept
//   st_req/adr/sel/dat byte-masked store requester, st_rdy accept
//   rd_req/adr         read requester, rd_rdy accept
//   rd_vld, rd_dat     read data one cycle after acceptance
//   sram_wr/sel/wadr/i registered SRAM write port
//   sram_radr          SRAM read address (combinational from rd_adr)
//   sram_o             SRAM read data
//
// Configuration macro: SRAM_ARB_STARVE_EN
//   defined   - the store starvation counter forces store priority after
//               STARVE consecutive blocked store cycles
//   undefined - strict fill priority; a store can wait indefinitely
module sram_bw_wr_arb #(
    parameter int WID    = 512,
    parameter int DEP    = 256,
    parameter int STARVE = 4,
    localparam int NSEL  = WID / 8,
    localparam int AW    = $clog2(DEP)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fill_req,
    input  logic [AW-1:0]   fill_adr,
    input  logic [WID-1:0]  fill_dat,
    output logic            fill_rdy,
    input  logic            st_req,
    input  logic [AW-1:0]   st_adr,
    input  logic [NSEL-1:0] st_sel,
    input  logic [WID-1:0]  st_dat,
    output logic            st_rdy,
    input  logic            rd_req,
    input  logic [AW-1:0]   rd_adr,
    output logic            rd_rdy,
    output logic            rd_vld,
    output logic [WID-1:0]  rd_dat,
    output logic            sram_wr,
    output logic [NSEL-1:0] sram_sel,
    output logic [AW-1:0]   sram_wadr,
    output logic [WID-1:0]  sram_i,
    output logic [AW-1:0]   sram_radr,
    input  logic [WID-1:0]  sram_o
);

    if (STARVE < 1 || STARVE > 15) begin : g_starve_range
        $error("sram_bw_wr_arb: STARVE must be in 1..15");
    end

    logic force_pri;
    logic fill_acc;
    logic st_acc;
    logic wr_d1;
    logic [AW-1:0] wadr_d1;

`ifdef SRAM_ARB_STARVE_EN
    localparam logic [3:0] STARVE_V = 4'(STARVE);
    logic [3:0] scnt;

    assign force_pri = (scnt == STARVE_V);

    // Counts consecutive cycles a store is waiting; saturates so force
    // stays asserted until the store finally goes through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scnt <= 4'd0;
        end else if (st_acc) begin
            scnt <= 4'd0;
        end else if (st_req && !st_rdy && scnt != STARVE_V) begin
            scnt <= scnt + 4'd1;
        end
    end
`else
    assign force_pri = 1'b0;
`endif

    // The two ready terms are mutually exclusive whenever both requests are
    // up, so at most one write is accepted per cycle.
    assign fill_rdy = !(force_pri && st_req);
    assign st_rdy   = !fill_req || force_pri;
    assign fill_acc = fill_req && fill_rdy;
    assign st_acc   = st_req && st_rdy;

    // Write port register. A store with no byte enables is consumed but
    // produces no SRAM cycle, so address and data hold like an idle cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_wr   <= 1'b0;
            sram_sel  <= '0;
            sram_wadr <= '0;
            sram_i    <= '0;
        end else if (fill_acc) begin
            sram_wr   <= 1'b1;
            sram_sel  <= '1;
            sram_wadr <= fill_adr;
            sram_i    <= fill_dat;
        end else if (st_acc && (|st_sel)) begin
            sram_wr   <= 1'b1;
            sram_sel  <= st_sel;
            sram_wadr <= st_adr;
            sram_i    <= st_dat;
        end else begin
            sram_wr   <= 1'b0;
            sram_sel  <= '0;
        end
    end

    // Remember the write that the SRAM commits this edge so a read issued
    // next cycle cannot see stale data; no reliance on SRAM bypass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_d1   <= 1'b0;
            wadr_d1 <= '0;
            rd_vld  <= 1'b0;
        end else begin
            wr_d1   <= sram_wr;
            wadr_d1 <= sram_wadr;
            rd_vld  <= rd_req && rd_rdy;
        end
    end

    assign rd_rdy = !((sram_wr && (rd_adr == sram_wadr)) ||
                      (wr_d1 && (rd_adr == wadr_d1)));

    assign sram_radr = rd_adr;
    assign rd_dat    = sram_o;

endmodule

// File: tb/tb_sram_bw_wr_arb.sv
module tb_sram_bw_wr_arb;
  localparam int WID = 512;
  localparam int DEP = 256;
  localparam int STARVE = 4;
  localparam int NSEL = WID / 8;
  localparam int AW = $clog2(DEP);

`ifdef SRAM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  logic fill_req;
  logic [AW-1:0] fill_adr;
  logic [WID-1:0] fill_dat;
  logic fill_rdy;
  logic st_req;
  logic [AW-1:0] st_adr;
  logic [NSEL-1:0] st_sel;
  logic [WID-1:0] st_dat;
  logic st_rdy;
  logic rd_req;
  logic [AW-1:0] rd_adr;
  logic rd_rdy;
  logic rd_vld;
  logic [WID-1:0] rd_dat;
  logic sram_wr;
  logic [NSEL-1:0] sram_sel;
  logic [AW-1:0] sram_wadr;
  logic [WID-1:0] sram_i;
  logic [AW-1:0] sram_radr;
  logic [WID-1:0] sram_o;

  int total;
  int bad;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_bw_wr_arb #(.WID(WID), .DEP(DEP), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .fill_req(fill_req), .fill_adr(fill_adr), .fill_dat(fill_dat), .fill_rdy(fill_rdy),
    .st_req(st_req), .st_adr(st_adr), .st_sel(st_sel), .st_dat(st_dat), .st_rdy(st_rdy),
    .rd_req(rd_req), .rd_adr(rd_adr), .rd_rdy(rd_rdy), .rd_vld(rd_vld), .rd_dat(rd_dat),
    .sram_wr(sram_wr), .sram_sel(sram_sel), .sram_wadr(sram_wadr), .sram_i(sram_i),
    .sram_radr(sram_radr), .sram_o(sram_o)
  );

  // byte-write SRAM model, read latency 1
  logic [WID-1:0] mem [DEP];
  always @(posedge clk) begin
    if (!rst) begin
      for (int a = 0; a < DEP; a++) mem[a] <= '0;
      sram_o <= '0;
    end else begin
      if (sram_wr)
        for (int b = 0; b < NSEL; b++)
          if (sram_sel[b]) mem[sram_wadr][b*8 +: 8] <= sram_i[b*8 +: 8];
      sram_o <= mem[sram_radr];
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fill_req = 1'b0;
    st_req = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [WID-1:0] d;
    d = {64{8'h11}};
    rst = 1'b0;
    idle();
    fill_adr = '0; fill_dat = '0; st_adr = '0; st_sel = '0; st_dat = '0; rd_adr = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
    fill_req = 1'b1; fill_adr = 8'h05; fill_dat = d;
    tick();
    fill_req = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (sram_wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", sram_wr); end
    total++; if (sram_sel !== '0) begin bad++; $display("FAIL reset_sel got=%h exp=0", sram_sel); end
    total++; if (sram_wadr !== '0) begin bad++; $display("FAIL reset_wadr got=%h exp=0", sram_wadr); end
    total++; if (sram_i !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", sram_i[63:0]); end
    total++; if (rd_vld !== 1'b0) begin bad++; $display("FAIL reset_rd_vld got=%b exp=0", rd_vld); end
    tick();
    rst = 1'b1;
    tick();
    total++; if (sram_wr !== 1'b0) begin bad++; $display("FAIL reset_release_wr got=%b exp=0", sram_wr); end
  endtask

  task automatic test_fill();
    logic [WID-1:0] d;
    d = {64{8'hA5}};
    fill_req = 1'b1; fill_adr = 8'h10; fill_dat = d;
    #1;
    total++; if (fill_rdy !== 1'b1) begin bad++; $display("FAIL fill_rdy got=%b exp=1", fill_rdy); end
    tick();
    fill_req = 1'b0;
    total++; if (sram_wr !== 1'b1) begin bad++; $display("FAIL fill_wr got=%b exp=1", sram_wr); end
    total++; if (sram_sel !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL fill_sel got=%h exp=all ones", sram_sel); end
    total++; if (sram_wadr !== 8'h10) begin bad++; $display("FAIL fill_wadr got=%h exp=10", sram_wadr); end
    total++; if (sram_i !== d) begin bad++; $display("FAIL fill_data got=%h exp=a5..", sram_i[63:0]); end
    tick();
    total++; if (sram_wr !== 1'b0 || sram_sel !== '0) begin bad++; $display("FAIL fill_idle got wr=%b sel=%h exp wr=0 sel=0", sram_wr, sram_sel); end
    total++; if (sram_wadr !== 8'h10) begin bad++; $display("FAIL fill_hold_adr got=%h exp=10", sram_wadr); end
  endtask

  task automatic test_store_read();
    logic [WID-1:0] d;
    logic [WID-1:0] e;
    d = {64{8'hFF}};
    d[7:0] = 8'h3C;
    e = {64{8'hA5}};
    e[7:0] = 8'h3C;
    st_req = 1'b1; st_adr = 8'h10; st_sel = 64'h1; st_dat = d;
    #1;
    total++; if (st_rdy !== 1'b1) begin bad++; $display("FAIL store_rdy got=%b exp=1", st_rdy); end
    tick();
    st_req = 1'b0;
    total++; if (sram_wr !== 1'b1 || sram_sel !== 64'h1) begin bad++; $display("FAIL store_port got wr=%b sel=%h exp wr=1 sel=1", sram_wr, sram_sel); end
    rd_req = 1'b1; rd_adr = 8'h10;
    #1;
    total++; if (rd_rdy !== 1'b0) begin bad++; $display("FAIL hazard_cyc1 got=%b exp=0", rd_rdy); end
    tick();
    total++; if (rd_rdy !== 1'b0) begin bad++; $display("FAIL hazard_cyc2 got=%b exp=0", rd_rdy); end
    total++; if (rd_vld !== 1'b0) begin bad++; $display("FAIL hazard_vld got=%b exp=0", rd_vld); end
    tick();
    total++; if (rd_rdy !== 1'b1) begin bad++; $display("FAIL hazard_clear got=%b exp=1", rd_rdy); end
    tick();
    rd_req = 1'b0;
    total++; if (rd_vld !== 1'b1) begin bad++; $display("FAIL store_rd_vld got=%b exp=1", rd_vld); end
    total++; if (rd_dat !== e) begin bad++; $display("FAIL store_rd_dat got=%h exp=%h", rd_dat[63:0], e[63:0]); end
    tick();
    total++; if (rd_vld !== 1'b0) begin bad++; $display("FAIL rd_vld_drop got=%b exp=0", rd_vld); end
  endtask

  task automatic test_starve();
    logic exp_st;
    logic st_done;
    st_done = 1'b0;
    fill_req = 1'b1; fill_adr = 8'h40; fill_dat = {64{8'h77}};
    st_req = 1'b1; st_adr = 8'h30; st_sel = 64'hFF; st_dat = {64{8'h99}};
    for (int c = 1; c <= 10; c++) begin
      exp_st = STARVE_ON && (c == 5);
      #1;
      total++; if (st_rdy !== exp_st) begin bad++; $display("FAIL starve_st_rdy c=%0d got=%b exp=%b", c, st_rdy, exp_st); end
      if (!st_done) begin
        total++; if (fill_rdy !== !exp_st) begin bad++; $display("FAIL starve_fill_rdy c=%0d got=%b exp=%b", c, fill_rdy, !exp_st); end
      end
      tick();
      if (exp_st) begin
        st_req = 1'b0;
        st_done = 1'b1;
      end
      total++; if (sram_wr !== 1'b1 || sram_wadr !== (exp_st ? 8'h30 : 8'h40)) begin
        bad++; $display("FAIL starve_port c=%0d got wr=%b adr=%h", c, sram_wr, sram_wadr);
      end
    end
    fill_req = 1'b0;
    if (!st_done) begin
      #1;
      total++; if (st_rdy !== 1'b1) begin bad++; $display("FAIL starve_release got=%b exp=1", st_rdy); end
      tick();
      st_req = 1'b0;
      total++; if (sram_wadr !== 8'h30 || sram_sel !== 64'hFF) begin bad++; $display("FAIL starve_late_store got adr=%h sel=%h", sram_wadr, sram_sel); end
    end
    tick(); tick();
  endtask

  task automatic test_sel_zero();
    logic exp_st;
    fill_req = 1'b1; fill_adr = 8'h41; fill_dat = '0;
    st_req = 1'b1; st_adr = 8'h77; st_sel = '0; st_dat = {64{8'hEE}};
    tick(); tick();
    fill_req = 1'b0;
    #1;
    total++; if (st_rdy !== 1'b1) begin bad++; $display("FAIL selz_rdy got=%b exp=1", st_rdy); end
    tick();
    total++; if (sram_wr !== 1'b0 || sram_sel !== '0) begin bad++; $display("FAIL selz_drop got wr=%b sel=%h exp wr=0 sel=0", sram_wr, sram_sel); end
    // counter must have restarted from zero: four blocked cycles before force
    fill_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      exp_st = STARVE_ON && (c == 5);
      #1;
      total++; if (st_rdy !== exp_st) begin bad++; $display("FAIL selz_scnt c=%0d got=%b exp=%b", c, st_rdy, exp_st); end
      tick();
    end
    idle();
    tick(); tick();
  endtask

  task automatic test_no_hazard();
    fill_req = 1'b1; fill_adr = 8'h21; fill_dat = {64{8'h42}};
    rd_req = 1'b1; rd_adr = 8'h20;
    #1;
    total++; if (rd_rdy !== 1'b1) begin bad++; $display("FAIL nohaz_rdy1 got=%b exp=1", rd_rdy); end
    tick();
    fill_req = 1'b0;
    #1;
    total++; if (rd_rdy !== 1'b1) begin bad++; $display("FAIL nohaz_rdy2 got=%b exp=1", rd_rdy); end
    total++; if (rd_vld !== 1'b1) begin bad++; $display("FAIL nohaz_vld got=%b exp=1", rd_vld); end
    total++; if (rd_dat !== '0) begin bad++; $display("FAIL nohaz_dat got=%h exp=0", rd_dat[63:0]); end
    tick();
    rd_req = 1'b0;
    tick();
    total++; if (rd_vld !== 1'b0) begin bad++; $display("FAIL nohaz_end got=%b exp=0", rd_vld); end
  endtask

  task automatic test_both_scnt0();
    logic exp_st;
    fill_req = 1'b1; fill_adr = 8'h50; fill_dat = {64{8'h5A}};
    st_req = 1'b1; st_adr = 8'h51; st_sel = '1; st_dat = {64{8'hC3}};
    #1;
    total++; if (fill_rdy !== 1'b1 || st_rdy !== 1'b0) begin bad++; $display("FAIL both_rdy got fill=%b st=%b exp fill=1 st=0", fill_rdy, st_rdy); end
    tick();
    total++; if (sram_wadr !== 8'h50 || sram_i !== {64{8'h5A}}) begin bad++; $display("FAIL both_winner got adr=%h dat=%h exp adr=50", sram_wadr, sram_i[63:0]); end
    for (int c = 2; c <= 5; c++) begin
      exp_st = STARVE_ON && (c == 5);
      #1;
      total++; if (st_rdy !== exp_st) begin bad++; $display("FAIL both_scnt c=%0d got=%b exp=%b", c, st_rdy, exp_st); end
      tick();
    end
    idle();
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_fill();
    test_store_read();
    test_starve();
    test_sel_zero();
    test_no_hazard();
    test_both_scnt0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_bw_wr_arb.md
# sram_bw_wr_arb

Write-port arbiter and read scheduler for the byte-write line SRAM (`WID`-bit lines, `DEP` entries, 1-cycle read latency) used in the cache datapath. Two write requesters share the single SRAM write port: a full-line fill port and a byte-masked store port. The block also issues reads and holds off any read that would race an in-flight write. All SRAM write-side signals are registered outputs of this block.

## Interface
- `WID`, 512, line width in bits; `NSEL = WID/8` byte selects
- `DEP`, 256, SRAM depth; `AW = $clog2(DEP)`
- `STARVE`, 4, consecutive blocked store-request cycles before the store port gets forced priority (1..15)
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `fill_req`  in  1  fill write valid
- `fill_adr`  in  AW  fill line address
- `fill_dat`  in  WID  fill data; all bytes written
- `fill_rdy`  out  1  fill accepted this cycle when `fill_req & fill_rdy`
- `st_req`  in  1  store write valid
- `st_adr`  in  AW  store line address
- `st_sel`  in  NSEL  store byte enables
- `st_dat`  in  WID  store data
- `st_rdy`  out  1  store accepted when `st_req & st_rdy`
- `rd_req`  in  1  read valid
- `rd_adr`  in  AW  read address
- `rd_rdy`  out  1  read accepted when `rd_req & rd_rdy`
- `rd_vld`  out  1  read data valid
- `rd_dat`  out  WID  read data (= `sram_o`)
- `sram_wr`  out  1  SRAM write strobe
- `sram_sel`  out  NSEL  SRAM byte enables
- `sram_wadr`  out  AW  SRAM write address
- `sram_i`  out  WID  SRAM write data
- `sram_radr`  out  AW  SRAM read address (= `rd_adr`, combinational)
- `sram_o`  in  WID  SRAM read data

## Operation
- Write arbitration, combinational: `force = (scnt == STARVE)`.
  - `fill_rdy = !(force & st_req)`.
  - `st_rdy = !fill_req | force`.
  - At most one write is accepted per cycle.
- Accepted write registers onto the SRAM port at the same edge.
  - Fill: `sram_sel = all ones`, `sram_i = fill_dat`.
  - Store: `sram_sel = st_sel`, `sram_i = st_dat`.
  - In both cases `sram_wr = 1`.
  - With no acceptance: `sram_wr = 0` and `sram_sel = 0`; address and data hold.
- A store with `st_sel == 0` is accepted but drives `sram_wr = 0` (dropped, no SRAM cycle).
- Starvation counter `scnt` (4 bits):
  - increments on each cycle `st_req & !st_rdy`, saturating at `STARVE`;
  - clears on store acceptance.
- Read hazard: `rd_rdy = 0` when `rd_adr` equals either of:
  - `sram_wadr` while `sram_wr = 1`;
  - the write address of the previous cycle while that cycle's `sram_wr = 1` (register `wadr_d1`/`wr_d1`).
  - Otherwise `rd_rdy = 1`.
  - Reads never depend on SRAM internal bypass.
- `rd_vld` is the registered value of `rd_req & rd_rdy`. `rd_dat` passes `sram_o` through.
- Reset: asynchronous, active-low.
  - All registered outputs and state clear: `sram_wr`, `sram_sel`, `sram_wadr`, `sram_i`, `rd_vld`, `scnt`, `wr_d1`, `wadr_d1` all 0.
  - Reset mid-write drops the write; there is no replay.

## Timing
- Write: accepted at edge N; `sram_wr` high in cycle N..N+1; the SRAM commits at edge N+1.
- Read: accepted at edge N; `rd_vld` high and `rd_dat` valid in cycle N..N+1 (SRAM RL=1).
- Read blocked by a write to the same address: `rd_rdy` low for 2 cycles after that write's acceptance, then high.
- Simultaneous fill and store with `scnt < STARVE`: the fill wins and `scnt` increments.
- Simultaneous fill and store with `scnt == STARVE`: the store wins, `scnt` clears, and the fill retries the next cycle.
- Back-to-back writes: one per cycle, sustained.

## Configuration
- `SRAM_ARB_STARVE_EN`
  - Defined: the starvation counter and forced store priority operate as above.
  - Undefined: strict fill priority. `force` is tied to 0, `scnt` is not built, `st_rdy = !fill_req`, and a store can wait indefinitely.

## Test plan
- Reset with `rst = 0` mid-stream, then release -> all outputs 0. First fill, `fill_adr = 0x10`, `fill_dat = {64{8'hA5}}` -> `sram_wr = 1`, `sram_sel = 64'hFFFF_FFFF_FFFF_FFFF` one cycle later.
- Store to 0x10 with `st_sel = 64'h1` and `st_dat[7:0] = 8'h3C`, then read 0x10 -> `rd_rdy` low for 2 cycles; then `rd_vld` with byte 0 = `3C` and bytes 1..63 = `A5`.
- `fill_req` held high for 10 cycles with `st_req` held high and `STARVE = 4` -> store accepted on the 5th cycle, fill stalled exactly that cycle. Without the macro, the store is never accepted while the fill is held.
- Store with `st_sel = 0` -> `st_rdy = 1`, `sram_wr = 0`, `scnt` clears.
- Read 0x20 while writing 0x21 -> `rd_rdy = 1` with no stall; `rd_vld` arrives the next cycle.
- Fill and store both high in the same cycle with `scnt = 0` -> only `fill_rdy = 1`. The SRAM receives `fill_dat`, and `scnt` becomes 1.
